mac_issue_ctrl: RTL and testbench

// - Initiator side of the MAC EN/DONE handshake.
// - Accepts operand triples (A,B,C) on a valid/ready stream and issues each to one MAC: drives MAC_EN, holds operands, waits for MAC_DONE.
// - Captures MAC_MOUT into a result register and presents it on a valid/ready output stream.
// - Sits between operand fetch and result writeback; watchdog flags a hung MAC.

---
 rtl/mac_pkg.sv | 16 +
 rtl/mac_issue_ctrl.sv | 152 +++++++++++++++
 tb/tb_mac_issue_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared MAC definitions: controller state encoding and the default
// fixed-point widths agreed between the issue controller and the MAC.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    GUARD = 2'b10
  } mac_state_e;

  localparam int unsigned MAC_A_BITWIDTH    = 8;
  localparam int unsigned MAC_OUT_BITWIDTH  = 16;
  localparam int unsigned MAC_A_FRAC_BITS   = 6;
  localparam int unsigned MAC_OUT_FRAC_BITS = 12;

endpackage

// File: rtl/mac_issue_ctrl.sv
// Initiator side of the MAC EN/DONE handshake: issues one operand triple at a
// time, captures the result (or a watchdog abort) and presents it downstream.
module mac_issue_ctrl
  import mac_pkg::*;
#(
  parameter int unsigned A_BITWIDTH     = MAC_A_BITWIDTH,
  parameter int unsigned B_BITWIDTH     = 8,
  parameter int unsigned C_BITWIDTH     = 8,
  parameter int unsigned OUT_BITWIDTH   = MAC_OUT_BITWIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_BITWIDTH   = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [A_BITWIDTH-1:0]   IN_A,
  input  logic [B_BITWIDTH-1:0]   IN_B,
  input  logic [C_BITWIDTH-1:0]   IN_C,
  output logic                    MAC_EN,
  output logic [A_BITWIDTH-1:0]   MAC_A,
  output logic [B_BITWIDTH-1:0]   MAC_B,
  output logic [C_BITWIDTH-1:0]   MAC_C,
  input  logic [OUT_BITWIDTH-1:0] MAC_MOUT,
  input  logic                    MAC_DONE,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [OUT_BITWIDTH-1:0] OUT_DATA,
  output logic                    OUT_TIMEOUT,
  output logic                    BUSY,
  output logic [CNT_BITWIDTH-1:0] OP_COUNT
);

  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  mac_state_e              state_q, state_d;
  logic                    mac_en_q, mac_en_d;
  logic [A_BITWIDTH-1:0]   a_q, a_d;
  logic [B_BITWIDTH-1:0]   b_q, b_d;
  logic [C_BITWIDTH-1:0]   c_q, c_d;
  logic [WDOG_W-1:0]       wdog_q, wdog_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_BITWIDTH-1:0] out_data_q, out_data_d;
  logic                    out_timeout_q, out_timeout_d;
  logic [CNT_BITWIDTH-1:0] op_count_q, op_count_d;
  logic                    busy_q, busy_d;
  logic                    in_ready_c;

  // One op in flight and one result buffered: issue only when both are free.
  assign in_ready_c = (state_q == IDLE) && !out_valid_q;

  // Next-state and datapath update.
  always_comb begin
    state_d       = state_q;
    mac_en_d      = mac_en_q;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;
    wdog_d        = wdog_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_timeout_d = out_timeout_q;
    op_count_d    = op_count_q;

    if (out_valid_q && OUT_READY) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (IN_VALID && in_ready_c) begin
          a_d      = IN_A;
          b_d      = IN_B;
          c_d      = IN_C;
          mac_en_d = 1'b1;
          wdog_d   = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        mac_en_d = 1'b1;
        wdog_d   = wdog_q + WDOG_W'(1);
        // DONE takes priority over a watchdog expiry in the same cycle.
        if (MAC_DONE) begin
          out_data_d    = MAC_MOUT;
          out_timeout_d = 1'b0;
          out_valid_d   = 1'b1;
          op_count_d    = op_count_q + CNT_BITWIDTH'(1);
          mac_en_d      = 1'b0;
          state_d       = GUARD;
        end else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
          out_data_d    = '0;
          out_timeout_d = 1'b1;
          out_valid_d   = 1'b1;
          mac_en_d      = 1'b0;
          state_d       = GUARD;
        end
      end
      GUARD: begin
        // One EN-low cycle lets the MAC fall back to idle and drop DONE.
        mac_en_d = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        mac_en_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      mac_en_q      <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      wdog_q        <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_timeout_q <= 1'b0;
      op_count_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mac_en_q      <= mac_en_d;
      a_q           <= a_d;
      b_q           <= b_d;
      c_q           <= c_d;
      wdog_q        <= wdog_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_timeout_q <= out_timeout_d;
      op_count_q    <= op_count_d;
      busy_q        <= busy_d;
    end
  end

  assign IN_READY    = in_ready_c;
  assign MAC_EN      = mac_en_q;
  assign MAC_A       = a_q;
  assign MAC_B       = b_q;
  assign MAC_C       = c_q;
  assign OUT_VALID   = out_valid_q;
  assign OUT_DATA    = out_data_q;
  assign OUT_TIMEOUT = out_timeout_q;
  assign BUSY        = busy_q;
  assign OP_COUNT    = op_count_q;

endmodule

// File: tb/tb_mac_issue_ctrl.sv
// Directed bench for mac_issue_ctrl with a behavioural MAC whose DONE delay
// is programmable (negative delay = MAC never answers).
module tb_mac_issue_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [7:0]  IN_A, IN_B, IN_C;
  logic        MAC_EN;
  logic [7:0]  MAC_A, MAC_B, MAC_C;
  logic [15:0] MAC_MOUT;
  logic        MAC_DONE;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [15:0] OUT_DATA;
  logic        OUT_TIMEOUT;
  logic        BUSY;
  logic [15:0] OP_COUNT;

  mac_issue_ctrl dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_A(IN_A), .IN_B(IN_B), .IN_C(IN_C),
    .MAC_EN(MAC_EN), .MAC_A(MAC_A), .MAC_B(MAC_B), .MAC_C(MAC_C),
    .MAC_MOUT(MAC_MOUT), .MAC_DONE(MAC_DONE),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_DATA(OUT_DATA), .OUT_TIMEOUT(OUT_TIMEOUT),
    .BUSY(BUSY), .OP_COUNT(OP_COUNT)
  );

  always #5 CLK = ~CLK;

  // Behavioural MAC: A*B (6+6 frac bits) plus C aligned to 12 frac bits.
  function automatic logic [15:0] mac_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c);
    int p;
    p = int'($signed(a)) * int'($signed(b)) + int'($signed(c)) * 64;
    return 16'(p);
  endfunction

  int         dly;
  logic       spur;
  logic [4:0] mcnt;
  int         cyc;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (!MAC_EN) mcnt <= 5'd0;
    else if (mcnt != 5'h1F) mcnt <= mcnt + 5'd1;
  end

  assign MAC_DONE = spur || (MAC_EN && (dly >= 0) && (int'(mcnt) == dly));
  assign MAC_MOUT = mac_fn(MAC_A, MAC_B, MAC_C);

  int nvec;
  int nmis;
  logic [7:0] cur_a, cur_b, cur_c;
  logic [15:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Wait for IN_READY (bounded), present a triple for exactly one handshake.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    int n;
    n = 0;
    while (!IN_READY && n < 30) begin
      tick();
      n++;
    end
    chk("issue_in_ready", 32'(IN_READY), 32'd1);
    IN_A = a; IN_B = b; IN_C = c;
    cur_a = a; cur_b = b; cur_c = c;
    IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
  endtask

  // Cycles from handshake until OUT_VALID; operands checked while EN is high.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!OUT_VALID && lat < 40) begin
      if (MAC_EN) begin
        chk("mac_operands_stable", {8'd0, MAC_A, MAC_B, MAC_C}, {8'd0, cur_a, cur_b, cur_c});
      end
      tick();
      lat++;
    end
    if (!OUT_VALID) chk("out_valid_wait_expired", 32'(OUT_VALID), 32'd1);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    int          dly;
    logic [15:0] exp_d;
    logic        exp_to;
    int          exp_lat;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got stuck, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int last_cyc;
    int prev_dly;

    tbl[0]  = '{8'h40, 8'h20, 8'h10,  4, 16'h0C00, 1'b0,  6};
    tbl[1]  = '{8'hC0, 8'h40, 8'h00,  4, 16'hF000, 1'b0,  6};
    tbl[2]  = '{8'h7F, 8'h7F, 8'h7F,  4, 16'h5EC1, 1'b0,  6};
    tbl[3]  = '{8'h80, 8'h80, 8'h80,  4, 16'h2000, 1'b0,  6};
    tbl[4]  = '{8'h01, 8'hFF, 8'h00,  4, 16'hFFFF, 1'b0,  6};
    tbl[5]  = '{8'h20, 8'h20, 8'hF0,  4, 16'h0000, 1'b0,  6};
    tbl[6]  = '{8'h10, 8'hE0, 8'h20,  4, 16'h0600, 1'b0,  6};
    tbl[7]  = '{8'h55, 8'h03, 8'h01,  4, 16'h013F, 1'b0,  6};
    tbl[8]  = '{8'h40, 8'h40, 8'h00, 14, 16'h1000, 1'b0, 16};
    tbl[9]  = '{8'h12, 8'h34, 8'h56, -1, 16'h0000, 1'b1, 16};
    tbl[10] = '{8'h08, 8'h08, 8'h00,  0, 16'h0040, 1'b0,  2};

    nvec = 0; nmis = 0; cyc = 0;
    dly = 4; spur = 1'b0;
    RST = 1'b1; IN_VALID = 1'b0; IN_A = '0; IN_B = '0; IN_C = '0; OUT_READY = 1'b1;
    tick(); tick();
    RST = 1'b0;

    // Reset state
    chk("rst_in_ready", 32'(IN_READY), 32'd1);
    chk("rst_mac_en", 32'(MAC_EN), 32'd0);
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_op_count", 32'(OP_COUNT), 32'd0);
    chk("rst_mac_abc", {8'd0, MAC_A, MAC_B, MAC_C}, 32'd0);
    chk("rst_out_data", 32'(OUT_DATA), 32'd0);
    chk("rst_out_timeout", 32'(OUT_TIMEOUT), 32'd0);

    // Table: back-to-back stream with OUT_READY held high
    exp_cnt = 16'd0;
    last_cyc = 0;
    prev_dly = -2;
    for (int i = 0; i < 11; i++) begin
      dly = tbl[i].dly;
      issue(tbl[i].a, tbl[i].b, tbl[i].c);
      chk("busy_in_issue", 32'(BUSY), 32'd1);
      wait_out(lat);
      if (!tbl[i].exp_to) exp_cnt = exp_cnt + 16'd1;
      chk("latency", 32'(lat), 32'(tbl[i].exp_lat));
      chk("out_data", 32'(OUT_DATA), 32'(tbl[i].exp_d));
      chk("out_timeout", 32'(OUT_TIMEOUT), 32'(tbl[i].exp_to));
      chk("mac_en_dropped", 32'(MAC_EN), 32'd0);
      chk("busy_in_guard", 32'(BUSY), 32'd1);
      chk("op_count", 32'(OP_COUNT), 32'(exp_cnt));
      if (prev_dly == 4 && tbl[i].dly == 4) chk("stream_spacing", 32'(cyc - last_cyc), 32'd7);
      last_cyc = cyc;
      prev_dly = tbl[i].dly;
      tick();
      chk("out_valid_consumed", 32'(OUT_VALID), 32'd0);
      if (i == 7) chk("op_count_after_8", 32'(OP_COUNT), 32'd8);
    end

    // Backpressure: result held, no new issue while OUT_READY is low
    dly = 4;
    OUT_READY = 1'b0;
    issue(8'h40, 8'h40, 8'h40);
    wait_out(lat);
    exp_cnt = exp_cnt + 16'd1;
    chk("bp_data", 32'(OUT_DATA), 32'h2000);
    IN_A = 8'h10; IN_B = 8'h10; IN_C = 8'h00; IN_VALID = 1'b1;
    for (int k = 0; k < 20; k++) begin
      chk("bp_in_ready_low", 32'(IN_READY), 32'd0);
      chk("bp_out_valid_held", 32'(OUT_VALID), 32'd1);
      chk("bp_data_stable", 32'(OUT_DATA), 32'h2000);
      tick();
    end
    OUT_READY = 1'b1;
    tick();
    chk("bp_release_in_ready", 32'(IN_READY), 32'd1);
    cur_a = 8'h10; cur_b = 8'h10; cur_c = 8'h00;
    tick();
    IN_VALID = 1'b0;
    chk("bp_next_accepted", 32'(BUSY), 32'd1);
    wait_out(lat);
    exp_cnt = exp_cnt + 16'd1;
    chk("bp_next_data", 32'(OUT_DATA), 32'h0100);
    chk("bp_op_count", 32'(OP_COUNT), 32'(exp_cnt));
    tick();

    // Synchronous reset while in ISSUE
    issue(8'h40, 8'h20, 8'h10);
    tick(); tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("midrst_mac_en", 32'(MAC_EN), 32'd0);
    chk("midrst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("midrst_op_count", 32'(OP_COUNT), 32'd0);
    chk("midrst_in_ready", 32'(IN_READY), 32'd1);
    chk("midrst_busy", 32'(BUSY), 32'd0);
    issue(8'h40, 8'h20, 8'h10);
    wait_out(lat);
    chk("postrst_latency", 32'(lat), 32'd6);
    chk("postrst_data", 32'(OUT_DATA), 32'h0C00);
    chk("postrst_op_count", 32'(OP_COUNT), 32'd1);
    tick();

    // Spurious DONE in IDLE and GUARD is ignored
    spur = 1'b1;
    tick(); tick();
    spur = 1'b0;
    chk("spur_idle_out_valid", 32'(OUT_VALID), 32'd0);
    chk("spur_idle_op_count", 32'(OP_COUNT), 32'd1);
    chk("spur_idle_busy", 32'(BUSY), 32'd0);
    issue(8'h01, 8'h01, 8'h01);
    wait_out(lat);
    chk("spur_op_data", 32'(OUT_DATA), 32'h0041);
    spur = 1'b1;
    tick();
    spur = 1'b0;
    chk("spur_guard_out_valid", 32'(OUT_VALID), 32'd0);
    chk("spur_guard_op_count", 32'(OP_COUNT), 32'd2);
    chk("spur_guard_in_ready", 32'(IN_READY), 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
